full_adder_subtractor: RTL and testbench

FULL_ADDER_SUBTRACTOR -- requirements
Module: full_adder_subtractor

---
 rtl/full_adder_subtractor.sv | 103 ++++++++++
 tb/tb_full_adder_subtractor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_subtractor.sv
// Registered add/subtract/AND/OR unit built on a ripple chain of full-adder cells, one-cycle latency.
// Define FULL_ADDER_SUBTRACTOR_FLAGS_EN to compute zero/overflow; otherwise both ports are tied to 0.
module full_adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  op_e              op_sel;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_cout;

  assign op_sel = op_e'(op);

  // Subtract shares the adder chain: a + ~b + 1.
  always_comb begin
    bx       = (op_sel == OP_SUB) ? ~b : b;
    carry    = '0;
    carry[0] = (op_sel == OP_SUB);
    sum      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ bx[i] ^ carry[i];
      carry[i + 1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
    end
  end

  always_comb begin
    nxt_result = sum;
    nxt_cout   = carry[WIDTH];
    case (op_sel)
      OP_AND: begin
        nxt_result = a & b;
        nxt_cout   = 1'b0;
      end
      OP_OR: begin
        nxt_result = a | b;
        nxt_cout   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= nxt_result;
        cout   <= nxt_cout;
      end
    end
  end

`ifdef FULL_ADDER_SUBTRACTOR_FLAGS_EN
  logic nxt_zero;
  logic nxt_overflow;

  always_comb begin
    nxt_zero     = (nxt_result == '0);
    nxt_overflow = 1'b0;
    if (op_sel == OP_ADD || op_sel == OP_SUB) begin
      nxt_overflow = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else if (in_valid) begin
      zero     <= nxt_zero;
      overflow <= nxt_overflow;
    end
  end
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_subtractor.sv
// Self-checking bench for full_adder_subtractor: directed vector table, reset/hold sequences
// and a random stream, all checked through an expected-result scoreboard.
module tb_full_adder_subtractor;

  localparam int W = 8;
`ifdef FULL_ADDER_SUBTRACTOR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int pulses = 0;
  exp_t sb[$];

  full_adder_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .result   (result),
    .cout     (cout),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Independent reference: integer arithmetic and sign rules, not a carry chain.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    case (o)
      2'b00: begin
        s   = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0];
        e.c = s[W];
        e.o = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      2'b01: begin
        s   = {1'b0, x} - {1'b0, y};
        e.r = s[W-1:0];
        e.c = (x >= y);
        e.o = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      2'b10: e.r = x & y;
      default: e.r = x | y;
    endcase
    e.z = (e.r == '0);
    if (!FLAGS) begin
      e.z = 1'b0;
      e.o = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y, input logic push,
                       input exp_t e);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
    if (push) begin
      sb.push_back(e);
      pushed++;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("cout", W'(cout), W'(e.c));
        chk("zero", W'(zero), W'(e.z));
        chk("overflow", W'(overflow), W'(e.o));
      end
    end
  end

  vec_t vecs[22];

  initial begin
    exp_t e;
    exp_t last;
    vecs[0]  = '{2'b01, 8'd8,   8'd4,   8'd4,   1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 8'd11,  8'd6,   8'd5,   1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 8'd107, 8'd86,  8'd21,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 8'd1,   8'd2,   8'd255, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 8'd86,  8'd107, 8'd193, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b00, 8'd32,  8'd64,  8'd96,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 8'd127, 8'd1,   8'd128, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 8'hAA,  8'h00,  8'h00,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{2'b10, 8'hAA,  8'hAA,  8'hAA,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 8'hFF,  8'hFF,  8'hFF,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b10, 8'hAA,  8'h55,  8'h00,  1'b0, 1'b1, 1'b0};
    vecs[13] = '{2'b11, 8'hAA,  8'h00,  8'hAA,  1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'b11, 8'h00,  8'h00,  8'h00,  1'b0, 1'b1, 1'b0};
    vecs[15] = '{2'b11, 8'hAA,  8'h55,  8'hFF,  1'b0, 1'b0, 1'b0};
    vecs[16] = '{2'b11, 8'hFF,  8'hFF,  8'hFF,  1'b0, 1'b0, 1'b0};
    vecs[17] = '{2'b01, 8'd128, 8'd1,   8'd127, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{2'b00, 8'd255, 8'd1,   8'd0,   1'b1, 1'b1, 1'b0};
    vecs[19] = '{2'b01, 8'd5,   8'd5,   8'd0,   1'b1, 1'b1, 1'b0};
    vecs[20] = '{2'b00, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1, 1'b1};
    vecs[21] = '{2'b01, 8'd127, 8'd255, 8'd128, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result, '0);
    chk("reset_cout", W'(cout), '0);
    chk("reset_zero", W'(zero), W'(FLAGS));
    chk("reset_overflow", W'(overflow), '0);
    chk("reset_out_valid", W'(out_valid), '0);

    // Back-to-back table vectors, one per cycle.
    for (int i = 0; i < 22; i++) begin
      e.r = vecs[i].r;
      e.c = vecs[i].c;
      e.z = FLAGS ? vecs[i].z : 1'b0;
      e.o = FLAGS ? vecs[i].o : 1'b0;
      drive(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e);
      last = e;
    end

    // Idle cycles: outputs hold, no out_valid.
    drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, e);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'($urandom), W'($urandom), W'($urandom), 1'b0, e);
      @(negedge clk);
      chk("hold_result", result, last.r);
      chk("hold_cout", W'(cout), W'(last.c));
      chk("hold_zero", W'(zero), W'(last.z));
      chk("hold_overflow", W'(overflow), W'(last.o));
      chk("hold_out_valid", W'(out_valid), '0);
    end

    // Reset beats a valid op; the first cycle after reset is accepted normally.
    drive(1'b1, 1'b1, 2'b00, 8'd5, 8'd5, 1'b0, e);
    drive(1'b0, 1'b1, 2'b00, 8'd3, 8'd4, 1'b1, model(2'b00, 8'd3, 8'd4));
    @(negedge clk);
    chk("rstvalid_out_valid", W'(out_valid), '0);
    chk("rstvalid_result", result, '0);
    chk("rstvalid_zero", W'(zero), W'(FLAGS));
    chk("rstvalid_cout", W'(cout), '0);

    for (int i = 0; i < 300; i++) begin
      logic       v;
      logic [1:0] o;
      logic [W-1:0] x, y;
      v = ($urandom_range(0, 3) != 0);
      o = 2'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      if (i % 16 == 0) x = '0;
      if (i % 16 == 1) y = {W{1'b1}};
      drive(1'b0, v, o, x, y, v, model(o, x, y));
    end

    drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, e);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", W'(sb.size()), '0);
    checks++;
    if (pulses != pushed) begin
      errors++;
      $display("FAIL out_valid_count: got %0d pulses expected %0d", pulses, pushed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
